// File: rtl/pipe_buf_pkg.sv
// Shared defaults and width helpers for the pipe_buffer block.
package pipe_buf_pkg;

  localparam int DEF_WIDTH     = 32;
  localparam int DEF_DEPTH     = 8;
  localparam int DEF_AF_MARGIN = 2;

  // Occupancy needs one extra bit so that a full buffer (count == DEPTH) is representable.
  function automatic int count_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/pipe_buffer_if.sv
// Upstream/downstream handshake bundle for pipe_buffer.
interface pipe_buffer_if #(
  parameter int WIDTH = pipe_buf_pkg::DEF_WIDTH
);

  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             out_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;

  // Side that feeds words in and takes them out (the surrounding pipeline).
  modport master (
    output in_valid,
    output in_data,
    output out_ready,
    input  out_valid,
    input  out_data
  );

  // The buffer itself.
  modport slave (
    input  in_valid,
    input  in_data,
    input  out_ready,
    output out_valid,
    output out_data
  );

endinterface

// File: rtl/pipe_buf_mem.sv
// Storage array for pipe_buffer: one synchronous write port, one asynchronous read port, no reset.
module pipe_buf_mem #(
  parameter int WIDTH = pipe_buf_pkg::DEF_WIDTH,
  parameter int DEPTH = pipe_buf_pkg::DEF_DEPTH
) (
  input  logic                     clk,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [WIDTH-1:0]         rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Contents are deliberately left unreset; validity is tracked by the occupancy count.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/pipe_buffer.sv
// Circular FIFO pipeline buffer with near-full stall request and sticky overflow flag.
module pipe_buffer
  import pipe_buf_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int DEPTH     = DEF_DEPTH,
  parameter int AF_MARGIN = DEF_AF_MARGIN
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         flush,
  input  logic                         stall_in,
  pipe_buffer_if.slave                 bus,
  output logic                         to_stall_mgmt,
  output logic [count_width(DEPTH)-1:0] count,
  output logic                         overflow_err
);

  localparam int CW = count_width(DEPTH);
  localparam int PW = $clog2(DEPTH);
  localparam logic [CW-1:0] DEPTH_C    = CW'(DEPTH);
  localparam logic [CW-1:0] STALL_LVL  = CW'(DEPTH - AF_MARGIN);

  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW-1:0] wr_ptr_next, rd_ptr_next;
  logic [CW-1:0] count_next;
  logic          out_valid;
  logic          push, pop, full, wr_en, drop;

  assign out_valid     = (count != '0);
  assign bus.out_valid = out_valid;

  // Handshake decode and next-state for pointers and occupancy; flush wins over everything.
  always_comb begin
    push        = bus.in_valid & ~flush;
    pop         = out_valid & bus.out_ready & ~stall_in & ~flush;
    full        = (count == DEPTH_C);
    wr_en       = push & (~full | pop);
    drop        = push & full & ~pop;
    count_next  = count;
    wr_ptr_next = wr_ptr;
    rd_ptr_next = rd_ptr;
    if (wr_en) begin
      wr_ptr_next = wr_ptr + PW'(1);
    end
    if (pop) begin
      rd_ptr_next = rd_ptr + PW'(1);
    end
    case ({wr_en, pop})
      2'b10:   count_next = count + CW'(1);
      2'b01:   count_next = count - CW'(1);
      default: count_next = count;
    endcase
    if (flush) begin
      count_next  = '0;
      wr_ptr_next = '0;
      rd_ptr_next = '0;
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr_next;
      rd_ptr <= rd_ptr_next;
      count  <= count_next;
    end
  end

  // Near-full stall request tracks next occupancy; overflow flag is sticky until flush or reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      to_stall_mgmt <= 1'b0;
      overflow_err  <= 1'b0;
    end else if (flush) begin
      to_stall_mgmt <= 1'b0;
      overflow_err  <= 1'b0;
    end else begin
      to_stall_mgmt <= (count_next >= STALL_LVL);
      if (drop) begin
        overflow_err <= 1'b1;
      end
    end
  end

  pipe_buf_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wr_ptr),
    .wr_data (bus.in_data),
    .rd_addr (rd_ptr),
    .rd_data (bus.out_data)
  );

endmodule

// File: tb/tb_pipe_buffer.sv
// Scoreboard bench for pipe_buffer: a queue model predicts every word, count and flag.
module tb_pipe_buffer;
  import pipe_buf_pkg::*;

  localparam int WIDTH     = 32;
  localparam int DEPTH     = 8;
  localparam int AF_MARGIN = 2;

  logic                          clk;
  logic                          reset;
  logic                          flush;
  logic                          stall_in;
  logic                          to_stall_mgmt;
  logic [count_width(DEPTH)-1:0] count;
  logic                          overflow_err;

  pipe_buffer_if #(.WIDTH(WIDTH)) bus();

  pipe_buffer #(
    .WIDTH     (WIDTH),
    .DEPTH     (DEPTH),
    .AF_MARGIN (AF_MARGIN)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .flush         (flush),
    .stall_in      (stall_in),
    .bus           (bus.slave),
    .to_stall_mgmt (to_stall_mgmt),
    .count         (count),
    .overflow_err  (overflow_err)
  );

  int checks   = 0;
  int failures = 0;
  logic [WIDTH-1:0] sb_q[$];
  logic             ovf_m = 1'b0;

  // Free-running clock, rising edges at 5, 15, 25 ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", tag, actual, expected);
    end
  endtask

  // Drive one cycle, predict its effect at the falling edge, check registered outputs just after the rising edge.
  task automatic applyStimulus(input logic iv, input logic [WIDTH-1:0] data, input logic ready,
                               input logic stall, input logic fl);
    int   sz;
    logic push_m, pop_m;
    bus.in_valid  = iv;
    bus.in_data   = data;
    bus.out_ready = ready;
    stall_in      = stall;
    flush         = fl;
    @(negedge clk);
    sz     = sb_q.size();
    push_m = iv && !fl;
    pop_m  = (sz != 0) && ready && !stall && !fl;
    checkOutput("out_valid", 32'(bus.out_valid), 32'(sz != 0));
    if (sz != 0) checkOutput("out_data", bus.out_data, sb_q[0]);
    if (fl) begin
      sb_q.delete();
      ovf_m = 1'b0;
    end else begin
      if (pop_m) void'(sb_q.pop_front());
      if (push_m) begin
        if (sz < DEPTH || pop_m) sb_q.push_back(data);
        else ovf_m = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    checkOutput("count", 32'(count), 32'(sb_q.size()));
    checkOutput("to_stall_mgmt", 32'(to_stall_mgmt), 32'(sb_q.size() >= DEPTH - AF_MARGIN));
    checkOutput("overflow_err", 32'(overflow_err), 32'(ovf_m));
  endtask

  task automatic idle(input logic ready, input logic stall, input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, '0, ready, stall, 1'b0);
  endtask

  initial begin
    reset         = 1'b1;
    flush         = 1'b0;
    stall_in      = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    #1;
    checkOutput("reset_count", 32'(count), 32'd0);
    checkOutput("reset_out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("reset_stall", 32'(to_stall_mgmt), 32'd0);
    checkOutput("reset_ovf", 32'(overflow_err), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    $display("[TB] scenario 1: pass-through");
    applyStimulus(1'b1, 32'h11, 1'b1, 1'b0, 1'b0);
    checkOutput("s1_first_latency", bus.out_data, 32'h11);
    applyStimulus(1'b1, 32'h22, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h33, 1'b1, 1'b0, 1'b0);
    idle(1'b1, 1'b0, 2);

    $display("[TB] scenario 2/3: stall, near-full, overflow");
    for (int i = 0; i < 6; i++) applyStimulus(1'b1, 32'h100 + 32'(i), 1'b1, 1'b1, 1'b0);
    checkOutput("s2_stall_at6", 32'(to_stall_mgmt), 32'd1);
    checkOutput("s2_head_held", bus.out_data, 32'h100);
    for (int i = 6; i < 8; i++) applyStimulus(1'b1, 32'h100 + 32'(i), 1'b1, 1'b1, 1'b0);
    applyStimulus(1'b1, 32'hDEAD, 1'b1, 1'b1, 1'b0);
    checkOutput("s3_full_count", 32'(count), 32'd8);
    checkOutput("s3_ovf_set", 32'(overflow_err), 32'd1);
    idle(1'b1, 1'b0, 9);
    applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b1);

    $display("[TB] scenario 4: push and pop while full");
    for (int i = 0; i < 8; i++) applyStimulus(1'b1, 32'h200 + 32'(i), 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'hBEEF, 1'b1, 1'b0, 1'b0);
    checkOutput("s4_count", 32'(count), 32'd8);
    checkOutput("s4_no_ovf", 32'(overflow_err), 32'd0);
    for (int i = 0; i < 7; i++) applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0);
    checkOutput("s4_beef_eighth", bus.out_data, 32'hBEEF);
    idle(1'b1, 1'b0, 2);

    $display("[TB] scenario 5: flush");
    for (int i = 0; i < 9; i++) applyStimulus(1'b1, 32'h300 + 32'(i), 1'b0, 1'b0, 1'b0);
    idle(1'b1, 1'b0, 3);
    checkOutput("s5_count5", 32'(count), 32'd5);
    applyStimulus(1'b1, 32'h3FF, 1'b1, 1'b0, 1'b1);
    checkOutput("s5_out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("s5_ovf_clear", 32'(overflow_err), 32'd0);

    $display("[TB] scenario 6: async reset mid-drain");
    for (int i = 0; i < 6; i++) applyStimulus(1'b1, 32'h400 + 32'(i), 1'b0, 1'b0, 1'b0);
    idle(1'b1, 1'b0, 2);
    checkOutput("s6_count4", 32'(count), 32'd4);
    bus.out_ready = 1'b1;
    #2;
    reset = 1'b1;
    #1;
    checkOutput("s6_async_count", 32'(count), 32'd0);
    checkOutput("s6_async_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("s6_async_stall", 32'(to_stall_mgmt), 32'd0);
    checkOutput("s6_async_ovf", 32'(overflow_err), 32'd0);
    sb_q.delete();
    ovf_m = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    applyStimulus(1'b1, 32'h5A, 1'b0, 1'b0, 1'b0);
    checkOutput("s6_first_word", bus.out_data, 32'h5A);
    idle(1'b1, 1'b0, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipe_buffer.md
PIPE_BUFFER -- requirements
Module: pipe_buffer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, meaning data word width in bits.
REQ-002 The block SHALL have parameter DEPTH, default 8, meaning entry count, power of two, minimum 4.
REQ-003 The block SHALL have parameter AF_MARGIN, default 2, meaning free entries still remaining when the stall request asserts; this covers the stall-propagation latency.
REQ-004 Port list (name, direction, width, meaning):
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous clear of contents.
- in_valid  in  1  upstream word present.
- in_data  in  WIDTH  upstream word.
- stall_in  in  1  registered stall from stall management; blocks pop.
- out_ready  in  1  downstream able to take a word.
- out_valid  out  1  head word present.
- out_data  out  WIDTH  head word.
- to_stall_mgmt  out  1  registered near-full stall request.
- count  out  $clog2(DEPTH)+1  registered occupancy.
- overflow_err  out  1  sticky dropped-push flag.

Function
REQ-005 push SHALL equal in_valid AND NOT flush.
REQ-006 pop SHALL equal out_valid AND out_ready AND NOT stall_in AND NOT flush.
REQ-007 Storage SHALL be a circular array with read and write pointers of $clog2(DEPTH) bits, each wrapping from DEPTH-1 to 0.
REQ-008 out_valid SHALL equal (count != 0), and out_data SHALL equal the entry at the read pointer.
REQ-009 out_data SHALL be held stable while out_valid=1 and no pop occurs.
REQ-010 Latency: a word pushed in cycle N SHALL appear on out_valid/out_data in cycle N+1 when the buffer was empty.
REQ-011 Ordering SHALL be strict FIFO, with no duplication or loss of accepted words.
REQ-012 When count<DEPTH, a push SHALL write in_data at the write pointer and advance it.
REQ-013 When count==DEPTH, a push with a simultaneous pop SHALL be accepted and count SHALL stay at DEPTH.
REQ-014 When count==DEPTH, a push without a pop SHALL be dropped, the pointers SHALL be unchanged, and overflow_err SHALL set on the next edge.
REQ-015 A pop when count==0 is impossible by construction; no underflow state SHALL exist.
REQ-016 On push with pop, count SHALL be unchanged and both pointers SHALL advance; push only: count+1; pop only: count-1.
REQ-017 to_stall_mgmt SHALL be registered: on each edge it SHALL load (count_next >= DEPTH-AF_MARGIN) and SHALL deassert on the edge where count_next drops below that level.
REQ-018 flush SHALL zero both pointers, count and to_stall_mgmt, and clear overflow_err on the next edge.
REQ-019 flush SHALL override any simultaneous push or pop.
REQ-020 overflow_err SHALL remain set until reset or flush.

Reset
REQ-021 Asynchronous reset SHALL force pointers=0, count=0, out_valid=0, to_stall_mgmt=0 and overflow_err=0.
REQ-022 Storage contents SHALL NOT be reset, and out_data SHALL be don't-care while out_valid=0.
REQ-023 Reset asserted mid-operation SHALL discard all stored words; the first push after deassertion SHALL land in entry 0.

Structure
REQ-024 Package pipe_buf_pkg SHALL hold the default WIDTH, DEPTH and AF_MARGIN constants and a localparam function for the count width.
REQ-025 A sub-module pipe_buf_mem SHALL implement the storage array, with one write port and one asynchronous read port and no reset.
REQ-026 Pointer, count, flag and stall-request logic SHALL reside in pipe_buffer.

Verification
REQ-027 Scenario 1: reset, then push 0x11,0x22,0x33 on consecutive cycles with out_ready=1 and stall_in=0 -> out_data shows 0x11,0x22,0x33 starting one cycle after the first push; count peaks at 1.
REQ-028 Scenario 2: stall_in=1, push 6 words with DEPTH=8 and AF_MARGIN=2 -> to_stall_mgmt rises on the edge where count becomes 6, and out_valid stays 1 with out_data held at the first word.
REQ-029 Scenario 3: fill 8 words with stall_in=1, then push 0xDEAD -> count stays 8 and overflow_err=1; release the stall and drain -> 8 original words in order, 0xDEAD absent.
REQ-030 Scenario 4: full buffer, stall_in=0, out_ready=1 and push 0xBEEF in the same cycle -> count stays 8, no overflow, and 0xBEEF exits eighth.
REQ-031 Scenario 5: count=5 with overflow_err=1, assert flush alongside in_valid -> next cycle count=0, out_valid=0, overflow_err=0 and to_stall_mgmt=0.
REQ-032 Scenario 6: assert reset asynchronously mid-drain with count=4 -> outputs clear before the next clk edge; after deassertion, a push of 0x5A reappears as the first word.
